serial_adder: RTL and testbench

- Bit-serial, LSB-first ripple adder: one full-add per clock, a single carry flop carried between bit positions.
- Sequential counterpart to the team's combinational subtractor datapath; used where area matters more than latency (e.g. accumulate paths in small controllers).
- Loads two WIDTH-bit operands on a start handshake, produces sum, carry-out and signed overflow after WIDTH cycles, and signals completion with a one-cycle done pulse.

---
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-add per clock through a single carry flop.
// Loads operands on start and updates sum/cout/ovf together with a one-cycle done pulse.
module serial_adder #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-2:0]   s_sh_q, s_sh_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;

  logic               s_bit;
  logic               carry_nx;
  logic               last;
  logic               load;
  logic [WIDTH-1:0]   s_cat;

  assign s_bit    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
  assign carry_nx = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
  assign last     = (cnt_q == CNT_W'(WIDTH - 1));
  // A new operation may start from IDLE or straight out of DONE.
  assign load     = start && (state_q != RUN);
  assign s_cat    = {s_bit, s_sh_q};

  // NOTE: every always_comb output gets a default first, so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    if (load) begin
      a_sh_d  = a;
      b_sh_d  = b;
      carry_d = cin;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_sh_d  = a_sh_q >> 1;
      b_sh_d  = b_sh_q >> 1;
      s_sh_d  = s_cat[WIDTH-1:1];
      carry_d = carry_nx;
      cnt_d   = cnt_q + CNT_W'(1);
      if (last) begin
        // On the MSB step carry_q is the carry into the MSB.
        sum_d  = s_cat;
        cout_d = carry_nx;
        ovf_d  = carry_q ^ carry_nx;
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8 and WIDTH=13 on a shared clock.
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start13;
  logic [7:0]  a8, b8;
  logic [12:0] a13, b13;
  logic        cin8, cin13;
  logic        busy8, done8, cout8, ovf8;
  logic        busy13, done13, cout13, ovf13;
  logic [7:0]  sum8;
  logic [12:0] sum13;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(start13), .a(a13), .b(b13), .cin(cin13),
    .busy(busy13), .done(done13), .sum(sum13), .cout(cout13), .ovf(ovf13)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done on the selected DUT, counting busy cycles seen before it.
  task automatic wait_done(input bit sel, output int busy_cnt, output bit got);
    busy_cnt = 0;
    got      = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sel ? done13 : done8) begin
        got = 1'b1;
        break;
      end
      if (sel ? busy13 : busy8) busy_cnt++;
      tick();
    end
  endtask

  // Pulses start for one edge on the selected DUT and waits for completion.
  task automatic run_op(input bit sel, input logic [12:0] a, input logic [12:0] b, input logic c,
                        output int busy_cnt, output bit got);
    if (sel) begin
      a13 = a; b13 = b; cin13 = c; start13 = 1'b1;
    end else begin
      a8 = a[7:0]; b8 = b[7:0]; cin8 = c; start8 = 1'b1;
    end
    tick();
    start8  = 1'b0;
    start13 = 1'b0;
    wait_done(sel, busy_cnt, got);
  endtask

  task automatic directed8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                           input logic [7:0] es, input logic ec, input logic eo);
    int bc;
    bit got;
    run_op(1'b0, {5'd0, a}, {5'd0, b}, c, bc, got);
    check({tag, "_done"}, 32'(got), 32'd1);
    check({tag, "_sum"},  32'(sum8), 32'(es));
    check({tag, "_cout"}, 32'(cout8), 32'(ec));
    check({tag, "_ovf"},  32'(ovf8), 32'(eo));
    tick();
    check({tag, "_pulse"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int bc;
    bit got;
    bit seen;
    logic [12:0] ra, rb, mask;
    logic        rc;
    logic [13:0] ref_full;
    logic        ref_ovf;
    int          w;

    rst = 1'b1; start8 = 1'b0; start13 = 1'b0;
    a8 = '0; b8 = '0; cin8 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum",  32'(sum8),  32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst_ovf",  32'(ovf8),  32'd0);
    rst = 1'b0;
    tick();

    // First op with latency check: busy for exactly 8 cycles before done.
    run_op(1'b0, 13'h03C, 13'h05A, 1'b0, bc, got);
    check("lat_busy_cycles", 32'(bc), 32'd8);
    check("lat_done", 32'(got), 32'd1);
    check("lat_sum",  32'(sum8), 32'h96);
    check("lat_cout", 32'(cout8), 32'd0);
    check("lat_ovf",  32'(ovf8), 32'd1);
    tick();
    check("lat_pulse", 32'(done8), 32'd0);

    directed8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    directed8("80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    directed8("cin_only", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    directed8("7f_cin", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);

    // Start held high through RUN with changing operands, then accepted again from DONE.
    a8 = 8'h10; b8 = 8'h05; cin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'h11; b8 = 8'h22;
    wait_done(1'b0, bc, got);
    check("hold_busy_cycles", 32'(bc), 32'd8);
    check("hold_first_done", 32'(got), 32'd1);
    check("hold_first_sum", 32'(sum8), 32'h15);
    tick();
    start8 = 1'b0;
    check("hold_b2b_busy", 32'(busy8), 32'd1);
    wait_done(1'b0, bc, got);
    check("hold_second_done", 32'(got), 32'd1);
    check("hold_second_sum", 32'(sum8), 32'h33);
    tick();

    // Load a result with ovf=1 so the abort visibly clears outputs.
    directed8("pre_abort", 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1);
    a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_sum",  32'(sum8),  32'd0);
    check("abort_cout", 32'(cout8), 32'd0);
    check("abort_ovf",  32'(ovf8),  32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done8) seen = 1'b1;
      tick();
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // rst together with start: reset wins.
    rst = 1'b1; start8 = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    check("rst_start_busy", 32'(busy8), 32'd0);

    directed8("post_abort", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);

    // Random sweep on both widths against an arithmetic reference.
    for (int d = 0; d < 2; d++) begin
      w    = (d == 0) ? 8 : 13;
      mask = (d == 0) ? 13'h00FF : 13'h1FFF;
      for (int n = 0; n < 1000; n++) begin
        ra = 13'($urandom) & mask;
        rb = 13'($urandom) & mask;
        rc = 1'($urandom);
        ref_full = 14'(ra) + 14'(rb) + 14'(rc);
        ref_ovf  = (ra[w-1] == rb[w-1]) && (ref_full[w-1] != ra[w-1]);
        run_op(d[0], ra, rb, rc, bc, got);
        check("rnd_done", 32'(got), 32'd1);
        if (d == 0) begin
          check("rnd8_full", 32'({cout8, sum8}), 32'(ref_full[8:0]));
          check("rnd8_ovf",  32'(ovf8), 32'(ref_ovf));
        end else begin
          check("rnd13_full", 32'({cout13, sum13}), 32'(ref_full));
          check("rnd13_ovf",  32'(ovf13), 32'(ref_ovf));
        end
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
